ring_router_vc: RTL and testbench

- Parametrised next-generation cardinal ring router.
- Three bidirectional ports: clockwise (cw), counter-clockwise (ccw) and processing element (pe).
- Every input and output port has two single-entry virtual-channel buffers, VC0 (even) and VC1 (odd), selected by a free-running polarity bit.
- External link handshakes use VC[polarity]. Internal input-to-output switching uses VC[~polarity], so link traffic and switch traffic never contend for the same buffer.

---
 rtl/ring_router_vc.sv | 204 ++++++++++++++++++++
 tb/tb_ring_router_vc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_router_vc.sv
// Three-port (cw, ccw, pe) ring router with two single-entry VCs per input and output.
// Link handshakes use VC[polarity]; the internal switch uses VC[~polarity].
module ring_router_vc #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned DIR_BIT = 30,
    parameter int unsigned HOP_LSB = 18,
    parameter int unsigned HOP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              polarity,

    input  logic              cwsi,
    output logic              cwri,
    input  logic [DATA_W-1:0] cwdi,
    input  logic              ccwsi,
    output logic              ccwri,
    input  logic [DATA_W-1:0] ccwdi,
    input  logic              pesi,
    output logic              peri,
    input  logic [DATA_W-1:0] pedi,

    output logic              cwso,
    input  logic              cwro,
    output logic [DATA_W-1:0] cwdo,
    output logic              ccwso,
    input  logic              ccwro,
    output logic [DATA_W-1:0] ccwdo,
    output logic              peso,
    input  logic              pero,
    output logic [DATA_W-1:0] pedo
);

    // Port indices shared by inputs and outputs.
    localparam logic [1:0] PortCw  = 2'd0;
    localparam logic [1:0] PortCcw = 2'd1;
    localparam logic [1:0] PortPe  = 2'd2;

    logic              polarity_q;
    logic              in_full_q  [3][2];
    logic [DATA_W-1:0] in_data_q  [3][2];
    logic              out_full_q [3][2];
    logic [DATA_W-1:0] out_data_q [3][2];
    logic              rr_q       [3][2];

    logic              p;
    logic              v;
    logic [2:0]        si;
    logic [2:0]        ri;
    logic [2:0]        ro;
    logic [2:0]        so;
    logic [DATA_W-1:0] di         [3];
    logic [DATA_W-1:0] dout       [3];

    logic [DATA_W-1:0] in_v       [3];
    logic [DATA_W-1:0] mv_data    [3];
    logic [1:0]        dest       [3];
    logic [2:0]        want       [3];
    logic [2:0]        a_req;
    logic [2:0]        b_req;
    logic [1:0]        a_idx      [3];
    logic [1:0]        b_idx      [3];
    logic [2:0]        gnt;
    logic [1:0]        src        [3];
    logic [2:0]        rr_nxt;
    logic [2:0]        in_clr;

    assign p = polarity_q;
    assign v = ~polarity_q;
    assign polarity = polarity_q;

    assign si    = {pesi, ccwsi, cwsi};
    assign ro    = {pero, ccwro, cwro};
    assign di[0] = cwdi;
    assign di[1] = ccwdi;
    assign di[2] = pedi;

    assign cwri  = ri[0];
    assign ccwri = ri[1];
    assign peri  = ri[2];
    assign cwso  = so[0];
    assign ccwso = so[1];
    assign peso  = so[2];
    assign cwdo  = dout[0];
    assign ccwdo = dout[1];
    assign pedo  = dout[2];

    function automatic logic [DATA_W-1:0] shift_hop(input logic [DATA_W-1:0] d);
        logic [HOP_W-1:0] hop;
        logic [DATA_W-1:0] r;
        r   = d;
        hop = d[HOP_LSB +: HOP_W];
        r[HOP_LSB +: HOP_W] = hop >> 1;
        return r;
    endfunction

    // Link side: handshakes on VC[polarity].
    always_comb begin
        for (int x = 0; x < 3; x++) begin
            ri[x]   = ~in_full_q[x][p];
            so[x]   = out_full_q[x][p] & ro[x];
            dout[x] = out_full_q[x][p] ? out_data_q[x][p] : '0;
        end
    end

    // Route decode for the switch-side VC of each input.
    always_comb begin
        for (int x = 0; x < 3; x++) begin
            in_v[x]    = in_data_q[x][v];
            mv_data[x] = in_v[x];
            dest[x]    = in_v[x][DIR_BIT] ? PortCcw : PortCw;
            if (x != 2) begin
                if (!in_v[x][HOP_LSB]) begin
                    dest[x] = PortPe;
                end else begin
                    mv_data[x] = shift_hop(in_v[x]);
                end
            end
            for (int y = 0; y < 3; y++) begin
                want[x][y] = in_full_q[x][v] && (dest[x] == 2'(y));
            end
        end
    end

    // Ring outputs pair a single "ring" requester (own-direction input first) with pe.
    always_comb begin
        a_req[0] = want[0][0] | want[1][0];
        a_idx[0] = want[0][0] ? PortCw : PortCcw;
        b_req[0] = want[2][0];
        b_idx[0] = PortPe;
        a_req[1] = want[1][1] | want[0][1];
        a_idx[1] = want[1][1] ? PortCcw : PortCw;
        b_req[1] = want[2][1];
        b_idx[1] = PortPe;
        a_req[2] = want[0][2];
        a_idx[2] = PortCw;
        b_req[2] = want[1][2];
        b_idx[2] = PortCcw;
    end

    always_comb begin
        gnt    = '0;
        in_clr = '0;
        for (int y = 0; y < 3; y++) begin
            src[y]    = a_idx[y];
            rr_nxt[y] = rr_q[y][v];
            if (!out_full_q[y][v]) begin
                if (a_req[y] && b_req[y]) begin
                    gnt[y]    = 1'b1;
                    src[y]    = rr_q[y][v] ? b_idx[y] : a_idx[y];
                    rr_nxt[y] = ~rr_q[y][v];
                end else if (a_req[y]) begin
                    gnt[y] = 1'b1;
                    src[y] = a_idx[y];
                end else if (b_req[y]) begin
                    gnt[y] = 1'b1;
                    src[y] = b_idx[y];
                end
            end
        end
        for (int x = 0; x < 3; x++) begin
            for (int y = 0; y < 3; y++) begin
                if (gnt[y] && (src[y] == 2'(x))) begin
                    in_clr[x] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            polarity_q <= 1'b0;
            for (int x = 0; x < 3; x++) begin
                for (int c = 0; c < 2; c++) begin
                    in_full_q[x][c]  <= 1'b0;
                    in_data_q[x][c]  <= '0;
                    out_full_q[x][c] <= 1'b0;
                    out_data_q[x][c] <= '0;
                    rr_q[x][c]       <= 1'b0;
                end
            end
        end else begin
            polarity_q <= ~polarity_q;
            for (int x = 0; x < 3; x++) begin
                if (si[x] && ri[x]) begin
                    in_full_q[x][p] <= 1'b1;
                    in_data_q[x][p] <= di[x];
                end
                if (in_clr[x]) begin
                    in_full_q[x][v] <= 1'b0;
                end
                if (so[x]) begin
                    out_full_q[x][p] <= 1'b0;
                end
                if (gnt[x]) begin
                    out_full_q[x][v] <= 1'b1;
                    out_data_q[x][v] <= mv_data[src[x]];
                    rr_q[x][v]       <= rr_nxt[x];
                end
            end
        end
    end

endmodule

// File: tb/tb_ring_router_vc.sv
// Scoreboard bench for ring_router_vc: expected packets are queued per output port at
// send time and popped whenever the router presents a packet on that port.
module tb_ring_router_vc;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        cwsi, ccwsi, pesi, cwri, ccwri, peri;
    logic [63:0] cwdi, ccwdi, pedi;
    logic        cwso, ccwso, peso, cwro, ccwro, pero;
    logic [63:0] cwdo, ccwdo, pedo;

    logic [2:0]  si_v;
    logic [2:0]  ro_v;
    logic [63:0] di_v [3];
    logic [2:0]  ri_v;
    logic [2:0]  so_v;
    logic [63:0] dout_v [3];

    logic [63:0] q_cw[$];
    logic [63:0] q_ccw[$];
    logic [63:0] q_pe[$];

    logic        tb_par;
    int          n_checks = 0;
    int          n_errs   = 0;

    assign {pesi, ccwsi, cwsi} = si_v;
    assign {pero, ccwro, cwro} = ro_v;
    assign cwdi  = di_v[0];
    assign ccwdi = di_v[1];
    assign pedi  = di_v[2];
    assign ri_v  = {peri, ccwri, cwri};
    assign so_v  = {peso, ccwso, cwso};
    assign dout_v[0] = cwdo;
    assign dout_v[1] = ccwdo;
    assign dout_v[2] = pedo;

    ring_router_vc dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .cwsi     (cwsi),
        .cwri     (cwri),
        .cwdi     (cwdi),
        .ccwsi    (ccwsi),
        .ccwri    (ccwri),
        .ccwdi    (ccwdi),
        .pesi     (pesi),
        .peri     (peri),
        .pedi     (pedi),
        .cwso     (cwso),
        .cwro     (cwro),
        .cwdo     (cwdo),
        .ccwso    (ccwso),
        .ccwro    (ccwro),
        .ccwdo    (ccwdo),
        .peso     (peso),
        .pero     (pero),
        .pedo     (pedo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent parity model.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_par <= 1'b0;
        else        tb_par <= ~tb_par;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic dir, input logic [7:0] hop,
                                       input logic [63:0] payload);
        logic [63:0] d;
        d = payload;
        d[25:18] = hop;
        d[30] = dir;
        return d;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (so_v[0]) begin
                if (q_cw.size() > 0) check("cw_out", dout_v[0], q_cw.pop_front());
                else check("cw_spurious", so_v[0], 1'b0);
            end
            if (so_v[1]) begin
                if (q_ccw.size() > 0) check("ccw_out", dout_v[1], q_ccw.pop_front());
                else check("ccw_spurious", so_v[1], 1'b0);
            end
            if (so_v[2]) begin
                if (q_pe.size() > 0) check("pe_out", dout_v[2], q_pe.pop_front());
                else check("pe_spurious", so_v[2], 1'b0);
            end
        end
    end

    task automatic wait_par(input logic pv);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (tb_par != pv && n < 4);
    endtask

    task automatic send(input int port, input logic [63:0] d);
        int   n = 0;
        logic acc = 1'b0;
        si_v[port] = 1'b1;
        di_v[port] = d;
        do begin
            @(negedge clk);
            acc = ri_v[port];
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        si_v[port] = 1'b0;
        check("accept", acc, 1'b1);
    endtask

    task automatic send2(input int pa, input logic [63:0] da, input int pb, input logic [63:0] db);
        logic acc_a, acc_b;
        si_v[pa] = 1'b1;
        di_v[pa] = da;
        si_v[pb] = 1'b1;
        di_v[pb] = db;
        @(negedge clk);
        acc_a = ri_v[pa];
        acc_b = ri_v[pb];
        @(posedge clk); #1;
        si_v[pa] = 1'b0;
        si_v[pb] = 1'b0;
        check("accept2_a", acc_a, 1'b1);
        check("accept2_b", acc_b, 1'b1);
    endtask

    task automatic wait_drained(input string tag);
        int n = 0;
        while ((q_cw.size() + q_ccw.size() + q_pe.size()) != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 64'(q_cw.size() + q_ccw.size() + q_pe.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b, c, e;
        reset   = 1'b0;
        si_v    = '0;
        ro_v    = 3'b111;
        di_v[0] = '0;
        di_v[1] = '0;
        di_v[2] = '0;
        #12;
        check("rst_polarity", polarity, 1'b0);
        check("rst_ri", ri_v, 3'b111);
        check("rst_so", so_v, 3'b000);
        check("rst_cwdo", cwdo, 64'd0);
        check("rst_ccwdo", ccwdo, 64'd0);
        check("rst_pedo", pedo, 64'd0);

        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("pol_seq", polarity, (i % 2 == 1) ? 1'b1 : 1'b0);
            check("pol_model", polarity, tb_par);
        end

        // Eject: hop 0 on cw goes to pe unchanged, two cycles after accept.
        a = mk(1'b0, 8'h00, 64'hDEAD_BEEF_0000_1234);
        wait_par(1'b0);
        q_pe.push_back(a);
        send(0, a);
        @(negedge clk);
        check("eject_early", peso, 1'b0);
        @(negedge clk);
        check("eject_lat", peso, 1'b1);
        wait_drained("drain_eject");

        // Forward: ccw, DIR=1, hop 7 -> ccw out with hop 3.
        a = mk(1'b1, 8'h07, 64'h0123_4567_89AB_CDEF);
        wait_par(1'b1);
        q_ccw.push_back(mk(1'b1, 8'h03, 64'h0123_4567_89AB_CDEF));
        send(1, a);
        @(negedge clk);
        check("fwd_early", ccwso, 1'b0);
        @(negedge clk);
        check("fwd_lat", ccwso, 1'b1);
        wait_drained("drain_fwd");

        // Contention on cw_out VC0: ring wins first, then pe wins the rematch.
        a = mk(1'b0, 8'h01, 64'hAAAA_0000_0000_0001);
        b = mk(1'b0, 8'h05, 64'hBBBB_0000_0000_0002);
        wait_par(1'b0);
        q_cw.push_back(mk(1'b0, 8'h00, 64'hAAAA_0000_0000_0001));
        q_cw.push_back(b);
        send2(0, a, 2, b);
        wait_drained("drain_cont1");
        a = mk(1'b0, 8'h01, 64'hAAAA_0000_0000_0003);
        b = mk(1'b0, 8'h09, 64'hBBBB_0000_0000_0004);
        wait_par(1'b0);
        q_cw.push_back(b);
        q_cw.push_back(mk(1'b0, 8'h00, 64'hAAAA_0000_0000_0003));
        send2(0, a, 2, b);
        wait_drained("drain_cont2");

        // Backpressure: hold cw_out, fill both VCs on both sides, then drain in order.
        ro_v[0] = 1'b0;
        wait_par(1'b0);
        for (int i = 0; i < 4; i++) begin
            c = mk(1'b0, 8'h01, 64'hC000_0000_0000_0000 | 64'(i));
            q_cw.push_back(mk(1'b0, 8'h00, 64'hC000_0000_0000_0000 | 64'(i)));
            send(0, c);
        end
        @(negedge clk);
        check("bp_ri_a", cwri, 1'b0);
        check("bp_so_a", cwso, 1'b0);
        @(negedge clk);
        check("bp_ri_b", cwri, 1'b0);
        check("bp_so_b", cwso, 1'b0);
        check("bp_held", 64'(q_cw.size()), 64'd4);
        wait_par(1'b0);
        ro_v[0] = 1'b1;
        wait_drained("drain_bp");

        // Reset mid-flight with four packets parked behind stalled outputs.
        ro_v = 3'b000;
        wait_par(1'b0);
        send(0, mk(1'b0, 8'h00, 64'h5100_0000_0000_0001));
        send(0, mk(1'b0, 8'h00, 64'h5100_0000_0000_0002));
        send(2, mk(1'b1, 8'h02, 64'h5200_0000_0000_0003));
        send(2, mk(1'b1, 8'h02, 64'h5200_0000_0000_0004));
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        ro_v  = 3'b111;
        #1;
        check("mid_rst_so", so_v, 3'b000);
        check("mid_rst_ri", ri_v, 3'b111);
        check("mid_rst_pol", polarity, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end

        // Router still works after the flush.
        e = mk(1'b0, 8'h00, 64'h7777_0000_0000_00EE);
        wait_par(1'b1);
        q_pe.push_back(e);
        send(1, e);
        wait_drained("drain_post");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
